morse_keyer: RTL and testbench

MORSE_KEYER -- requirements
Module: morse_keyer

---
 rtl/morse_pkg.sv | 85 ++++++++
 rtl/morse_char_fifo.sv | 56 +++++
 rtl/morse_keyer.sv | 159 +++++++++++++++
 tb/tb_morse_keyer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse keyer: element/gap lengths in units,
// the keyer FSM state type and the character -> (len, code) lookup.
package morse_pkg;

  localparam int unsigned DOT_U  = 1;
  localparam int unsigned DASH_U = 3;
  localparam int unsigned EGAP_U = 1;
  localparam int unsigned CGAP_U = 3;
  localparam int unsigned WGAP_U = 4;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StMark,
    StEgap,
    StCgap,
    StWgap
  } state_e;

  // ok: keyable symbol; space: word gap request; neither set: unsupported.
  // code holds the elements right-aligned in code[len-1:0], MSB sent first,
  // 1 = dash, 0 = dot.
  typedef struct packed {
    logic       ok;
    logic       space;
    logic [2:0] len;
    logic [4:0] code;
  } morse_sym_t;

  function automatic morse_sym_t mk_sym(input logic [2:0] len, input logic [4:0] code);
    morse_sym_t s;
    s.ok    = 1'b1;
    s.space = 1'b0;
    s.len   = len;
    s.code  = code;
    return s;
  endfunction

  function automatic morse_sym_t morse_lookup(input logic [7:0] c);
    morse_sym_t s;
    s = '0;
    case (c)
      8'h20: s.space = 1'b1;
      "A":   s = mk_sym(3'd2, 5'b00001);
      "B":   s = mk_sym(3'd4, 5'b01000);
      "C":   s = mk_sym(3'd4, 5'b01010);
      "D":   s = mk_sym(3'd3, 5'b00100);
      "E":   s = mk_sym(3'd1, 5'b00000);
      "F":   s = mk_sym(3'd4, 5'b00010);
      "G":   s = mk_sym(3'd3, 5'b00110);
      "H":   s = mk_sym(3'd4, 5'b00000);
      "I":   s = mk_sym(3'd2, 5'b00000);
      "J":   s = mk_sym(3'd4, 5'b00111);
      "K":   s = mk_sym(3'd3, 5'b00101);
      "L":   s = mk_sym(3'd4, 5'b00100);
      "M":   s = mk_sym(3'd2, 5'b00011);
      "N":   s = mk_sym(3'd2, 5'b00010);
      "O":   s = mk_sym(3'd3, 5'b00111);
      "P":   s = mk_sym(3'd4, 5'b00110);
      "Q":   s = mk_sym(3'd4, 5'b01101);
      "R":   s = mk_sym(3'd3, 5'b00010);
      "S":   s = mk_sym(3'd3, 5'b00000);
      "T":   s = mk_sym(3'd1, 5'b00001);
      "U":   s = mk_sym(3'd3, 5'b00001);
      "V":   s = mk_sym(3'd4, 5'b00001);
      "W":   s = mk_sym(3'd3, 5'b00011);
      "X":   s = mk_sym(3'd4, 5'b01001);
      "Y":   s = mk_sym(3'd4, 5'b01011);
      "Z":   s = mk_sym(3'd4, 5'b01100);
      "0":   s = mk_sym(3'd5, 5'b11111);
      "1":   s = mk_sym(3'd5, 5'b01111);
      "2":   s = mk_sym(3'd5, 5'b00111);
      "3":   s = mk_sym(3'd5, 5'b00011);
      "4":   s = mk_sym(3'd5, 5'b00001);
      "5":   s = mk_sym(3'd5, 5'b00000);
      "6":   s = mk_sym(3'd5, 5'b10000);
      "7":   s = mk_sym(3'd5, 5'b11000);
      "8":   s = mk_sym(3'd5, 5'b11100);
      "9":   s = mk_sym(3'd5, 5'b11110);
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/morse_char_fifo.sv
// Character buffer for the Morse keyer. Power-of-two depth, pointers wrap
// naturally. Push is ignored when full and pop when empty; flush wins over both.
module morse_char_fifo #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign full    = (count_q == CntW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Storage, pointers and occupancy; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/morse_keyer.sv
// Morse keyer: buffers ASCII characters and keys them out as dots, dashes and
// gaps timed in units of UNIT_TICKS clocks. key_out is registered from the
// previous state, so it trails the FSM by one cycle without changing any span.
// Optional: define MORSE_KEYER_LOWERCASE_EN to key a-z like A-Z.
module morse_keyer
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_TICKS = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       abort,
  output logic       key_out,
  output logic       busy,
  output logic       err
);

  localparam int unsigned TickW = (UNIT_TICKS > 1) ? $clog2(UNIT_TICKS) : 1;

  logic             full, empty, push, pop;
  logic [7:0]       head, char_q, char_fold;
  morse_sym_t       sym;
  state_e           state_q;
  logic [TickW-1:0] tick_q;
  logic [1:0]       unit_q;
  logic [4:0]       code_q;
  logic [2:0]       rem_q;
  logic             key_q, err_q;
  logic [2:0]       span_u;
  logic             last_tick, span_done;

  morse_char_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(abort),
    .push (push),
    .pop  (pop),
    .wdata(in_data),
    .rdata(head),
    .full (full),
    .empty(empty)
  );

  assign in_ready = !full;
  assign push     = in_valid && !full && !abort;
  assign pop      = (state_q == StIdle) && !empty && !abort;

`ifdef MORSE_KEYER_LOWERCASE_EN
  assign char_fold = (char_q >= 8'h61 && char_q <= 8'h7a) ? (char_q - 8'h20) : char_q;
`else
  assign char_fold = char_q;
`endif

  assign sym = morse_lookup(char_fold);

  // Length in units of the span the current state must hold.
  always_comb begin
    span_u = 3'd1;
    unique case (state_q)
      StMark:  span_u = code_q[4] ? 3'(DASH_U) : 3'(DOT_U);
      StEgap:  span_u = 3'(EGAP_U);
      StCgap:  span_u = 3'(CGAP_U);
      StWgap:  span_u = 3'(WGAP_U);
      default: span_u = 3'd1;
    endcase
  end

  assign last_tick = (tick_q == TickW'(UNIT_TICKS - 1));
  assign span_done = last_tick && ({1'b0, unit_q} == span_u - 3'd1);

  // Keyer FSM with registered key/err outputs; counters clear on every state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      tick_q  <= '0;
      unit_q  <= '0;
      char_q  <= '0;
      code_q  <= '0;
      rem_q   <= '0;
      key_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      key_q <= (state_q == StMark) && !abort;
      if (abort) begin
        state_q <= StIdle;
        tick_q  <= '0;
        unit_q  <= '0;
      end else begin
        if (last_tick) begin
          tick_q <= '0;
          unit_q <= unit_q + 2'd1;
        end else begin
          tick_q <= tick_q + TickW'(1);
        end
        unique case (state_q)
          StIdle: begin
            tick_q <= '0;
            unit_q <= '0;
            if (!empty) begin
              char_q  <= head;
              state_q <= StLoad;
            end
          end
          StLoad: begin
            tick_q <= '0;
            unit_q <= '0;
            if (sym.space) begin
              state_q <= StWgap;
            end else if (sym.ok) begin
              // Left-align so the element being sent is always code_q[4].
              code_q  <= sym.code << (3'd5 - sym.len);
              rem_q   <= sym.len;
              state_q <= StMark;
            end else begin
              err_q   <= 1'b1;
              state_q <= StIdle;
            end
          end
          StMark: begin
            if (span_done) begin
              tick_q  <= '0;
              unit_q  <= '0;
              code_q  <= {code_q[3:0], 1'b0};
              rem_q   <= rem_q - 3'd1;
              state_q <= (rem_q == 3'd1) ? StCgap : StEgap;
            end
          end
          StEgap: begin
            if (span_done) begin
              tick_q  <= '0;
              unit_q  <= '0;
              state_q <= StMark;
            end
          end
          StCgap, StWgap: begin
            if (span_done) begin
              tick_q  <= '0;
              unit_q  <= '0;
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign key_out = key_q;
  assign err     = err_q;
  assign busy    = (state_q != StIdle) || !empty;

endmodule

// File: tb/tb_morse_keyer.sv
// Bench for morse_keyer: directed and random messages checked cycle by cycle
// against a dot/dash text model of the expected key line.
module tb_morse_keyer;

  localparam int unsigned U     = 4;
  localparam int unsigned DEPTH = 8;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data  = 8'h00;
  logic       abort    = 1'b0;
  logic       in_ready, key_out, busy, err;

  int n_tests = 0;
  int n_fail  = 0;

  string        letters[26];
  string        digits[10];
  byte unsigned msg[$];
  bit           exp_key[$];
  bit           exp_err[$];

  morse_keyer #(
    .UNIT_TICKS(U),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data (in_data),
    .abort   (abort),
    .key_out (key_out),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic string pat_of(input byte unsigned c);
    byte unsigned u;
    u = c;
`ifdef MORSE_KEYER_LOWERCASE_EN
    if (u >= 8'd97 && u <= 8'd122) u = u - 8'd32;
`endif
    if (u >= 8'd65 && u <= 8'd90) return letters[u - 8'd65];
    if (u >= 8'd48 && u <= 8'd57) return digits[u - 8'd48];
    return "";
  endfunction

  // Per-cycle key/err expectation: each character costs a fetch and a lookup
  // cycle, then its marks and gaps; unsupported characters flag err on lookup.
  task automatic build_model();
    exp_key.delete();
    exp_err.delete();
    foreach (msg[i]) begin
      string p;
      p = pat_of(msg[i]);
      exp_key.push_back(1'b0);
      exp_err.push_back(1'b0);
      exp_key.push_back(1'b0);
      exp_err.push_back(msg[i] != 8'd32 && p.len() == 0);
      if (msg[i] == 8'd32) begin
        repeat (4 * U) begin exp_key.push_back(1'b0); exp_err.push_back(1'b0); end
      end else if (p.len() > 0) begin
        for (int j = 0; j < p.len(); j++) begin
          if (j > 0) repeat (U) begin exp_key.push_back(1'b0); exp_err.push_back(1'b0); end
          repeat ((p[j] == "-") ? 3 * U : U) begin
            exp_key.push_back(1'b1);
            exp_err.push_back(1'b0);
          end
        end
        repeat (3 * U) begin exp_key.push_back(1'b0); exp_err.push_back(1'b0); end
      end
    end
  endtask

  task automatic run_msg(input string tag);
    int len;
    build_model();
    len = exp_key.size();
    for (int k = 0; k <= len; k++) begin
      if (k < msg.size()) begin
        in_valid = 1'b1;
        in_data  = msg[k];
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (k >= 1) begin
        check({tag, "/key"}, key_out, exp_key[k-1]);
        check({tag, "/err"}, err, exp_err[k-1]);
        check({tag, "/busy"}, busy, (k - 1 < len - 1));
      end
    end
    in_valid = 1'b0;
    repeat (2) step();
  endtask

  task automatic load_str(input string s);
    msg.delete();
    for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
  endtask

  initial begin
    int acc;
    bit any_high, any_err;
    byte unsigned c;
    int unsigned n, r;

    letters = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                "..-", "...-", ".--", "-..-", "-.--", "--.."};
    digits  = '{"-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
                "---..", "----."};

    // Reset state
    #1;
    check("rst/key", key_out, 1'b0);
    check("rst/err", err, 1'b0);
    check("rst/busy", busy, 1'b0);
    check("rst/ready", in_ready, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Directed messages
    load_str("E");   run_msg("E");
    load_str("A");   run_msg("A");
    load_str("E E"); run_msg("E_E");
    load_str("#");   run_msg("hash");
    load_str("e");   run_msg("lower_e");
    load_str("SOS 09"); run_msg("sos09");

    // Hold in_valid with 'O': one char popped, DEPTH buffered, then full.
    acc = 0;
    in_valid = 1'b1;
    in_data  = 8'h4f;
    for (int k = 0; k < 20; k++) begin
      if (in_ready) acc++;
      step();
    end
    check("full/accepted", acc, DEPTH + 1);
    check("full/ready", in_ready, 1'b0);
    check("full/key_on", key_out, 1'b1);
    abort = 1'b1;
    step();
    abort    = 1'b0;
    in_valid = 1'b0;
    check("flush/key", key_out, 1'b0);
    check("flush/ready", in_ready, 1'b1);
    check("flush/busy", busy, 1'b0);
    any_high = 1'b0;
    repeat (80) begin step(); any_high |= key_out; end
    check("flush/silent", any_high, 1'b0);

    // Abort during the dash of 'T' with more characters queued.
    in_valid = 1'b1;
    in_data = 8'h54; step();
    in_data = 8'h45; step();
    in_data = 8'h45; step();
    in_valid = 1'b0;
    repeat (4) step();
    check("abort/dash_on", key_out, 1'b1);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h4b;
    step();
    abort    = 1'b0;
    in_valid = 1'b0;
    check("abort/key", key_out, 1'b0);
    check("abort/ready", in_ready, 1'b1);
    check("abort/busy", busy, 1'b0);
    any_high = 1'b0;
    any_err  = 1'b0;
    repeat (80) begin step(); any_high |= key_out; any_err |= err; end
    check("abort/silent", any_high, 1'b0);
    check("abort/no_err", any_err, 1'b0);

    // Reset in the middle of a character.
    in_valid = 1'b1;
    in_data = 8'h4f; step();
    in_data = 8'h45; step();
    in_valid = 1'b0;
    repeat (5) step();
    check("midrst/key_on", key_out, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst/key", key_out, 1'b0);
    check("midrst/busy", busy, 1'b0);
    check("midrst/ready", in_ready, 1'b1);
    check("midrst/err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    any_high = 1'b0;
    repeat (60) begin step(); any_high |= key_out; end
    check("midrst/silent", any_high, 1'b0);
    check("midrst/idle", busy, 1'b0);

    // Random messages
    repeat (25) begin
      msg.delete();
      n = $urandom_range(1, 6);
      repeat (n) begin
        r = $urandom_range(0, 9);
        if (r <= 5)      c = 8'(65 + $urandom_range(0, 25));
        else if (r == 6) c = 8'(48 + $urandom_range(0, 9));
        else if (r == 7) c = 8'd32;
        else if (r == 8) begin
          r = $urandom_range(0, 2);
          c = (r == 0) ? 8'h23 : ((r == 1) ? 8'h3f : 8'h2e);
        end else c = 8'(97 + $urandom_range(0, 25));
        msg.push_back(c);
      end
      run_msg("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
